// File: rtl/ins_fetch_pkg.sv
// Shared constants for the layer-controller instruction path.
// Holds the instruction width, the opcode field layout (ins[63:62]) and the
// fetch sequencer state type used by ins_fetch.
package INS_CONST;

   localparam int INST_W = 64;

   // Opcode field position and encodings
   localparam int OP_MSB = 63;
   localparam int OP_LSB = 62;
   localparam logic [1:0] OP_LOAD   = 2'b00;
   localparam logic [1:0] OP_CALC   = 2'b01;
   localparam logic [1:0] OP_SAVE   = 2'b10;
   localparam logic [1:0] OP_CONFIG = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE,
      S_FETCH,
      S_ISSUE,
      S_DRAIN
   } fetch_state_e;

   function automatic logic [1:0] opcode_of(input logic [INST_W-1:0] ins);
      return ins[OP_MSB:OP_LSB];
   endfunction

endpackage

// File: rtl/ins_fetch_ram.sv
// Instruction RAM: simple dual-port, DEPTH x WIDTH.
// Host write port and fetch read port; synchronous read with 1-cycle latency,
// read-first on a same-address collision. The read data register is only
// updated when rd_en_i is high, so it doubles as the held instruction output.
// Ports:
//   clk, rst     clock, synchronous active-high reset (read register only)
//   wr_en_i      write strobe
//   wr_addr_i    write address
//   wr_data_i    write data
//   rd_en_i      read enable
//   rd_addr_i    read address
//   rd_data_o    registered read data
module ins_ram #(
   parameter int DEPTH = 1024,
   parameter int WIDTH = 64,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en_i,
   input  logic [AW-1:0]    wr_addr_i,
   input  logic [WIDTH-1:0] wr_data_i,
   input  logic             rd_en_i,
   input  logic [AW-1:0]    rd_addr_i,
   output logic [WIDTH-1:0] rd_data_o
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [WIDTH-1:0] rd_data_q;

   // Array contents are not reset so a mid-run reset keeps the program
   always_ff @(posedge clk) begin
      if (wr_en_i) begin
         mem[wr_addr_i] <= wr_data_i;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_data_q <= '0;
      end else if (rd_en_i) begin
         rd_data_q <= mem[rd_addr_i];
      end
   end

   assign rd_data_o = rd_data_q;

endmodule

// File: rtl/ins_fetch.sv
// ins_fetch: instruction source for the layer controller.
// The host preloads the instruction RAM, then pulses start. Instructions are
// issued in order on ins_valid/ins/ins_ready with one bubble cycle after each
// accept. After the last accept (or an abort) the block waits DRAIN_CYC
// consecutive cycles of working=0 and then pulses done.
// Optional build macro: INS_FETCH_PERF_EN adds stall_cnt/run_cnt counters.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   wr_en/addr/data host RAM write port (accepted in every state)
//   start           run request pulse
//   start_addr/len  first address and instruction count (0..DEPTH)
//   abort           stop issuing after the current handshake
//   busy            run in progress
//   done            one-cycle completion pulse
//   err             one-cycle pulse when start arrives while busy
//   ins_valid/ins   instruction output, held while valid
//   ins_ready       one-cycle accept pulse
//   working         controller activity flag
//   stall_cnt       (PERF) cycles in ISSUE with ins_ready=0, saturating
//   run_cnt         (PERF) cycles with busy=1, saturating
module ins_fetch
   import INS_CONST::*;
#(
   parameter int DEPTH = 1024,
   parameter int DRAIN_CYC = 4,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [AW-1:0]     wr_addr,
   input  logic [INST_W-1:0] wr_data,
   input  logic              start,
   input  logic [AW-1:0]     start_addr,
   input  logic [AW:0]       start_len,
   input  logic              abort,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic              ins_valid,
   output logic [INST_W-1:0] ins,
   input  logic              ins_ready,
   input  logic              working
`ifdef INS_FETCH_PERF_EN
   ,
   output logic [31:0]       stall_cnt,
   output logic [31:0]       run_cnt
`endif
);

   // Drain counter only needs to reach DRAIN_CYC-1; the terminal cycle
   // jumps straight to IDLE
   localparam int CW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
   localparam logic [CW-1:0] DRAIN_LAST = CW'(DRAIN_CYC - 1);
   localparam logic [AW:0]   REMAIN_ONE = {{AW{1'b0}}, 1'b1};

   fetch_state_e  state_q, state_d;
   logic [AW-1:0] pc_q, pc_d;
   logic [AW:0]   remain_q, remain_d;
   logic          abort_q, abort_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          done_q, done_d;
   logic          err_q, err_d;
   logic          rd_en;

   // The RAM read register is the ins output register: it loads only in
   // FETCH and therefore holds steady through ISSUE.
   ins_ram #(
      .DEPTH (DEPTH),
      .WIDTH (INST_W)
   ) u_ram (
      .clk       (clk),
      .rst       (rst),
      .wr_en_i   (wr_en),
      .wr_addr_i (wr_addr),
      .wr_data_i (wr_data),
      .rd_en_i   (rd_en),
      .rd_addr_i (pc_q),
      .rd_data_o (ins)
   );

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      remain_d = remain_q;
      abort_d  = abort_q;
      cnt_d    = cnt_q;
      done_d   = 1'b0;
      err_d    = 1'b0;
      rd_en    = 1'b0;

      if (start && (state_q != S_IDLE)) begin
         err_d = 1'b1;
      end

      case (state_q)
         S_IDLE: begin
            if (start) begin
               if (start_len != '0) begin
                  pc_d     = start_addr;
                  remain_d = start_len;
                  abort_d  = 1'b0;
                  state_d  = S_FETCH;
               end else begin
                  done_d = 1'b1;
               end
            end
         end
         S_FETCH: begin
            cnt_d = '0;
            if (abort) begin
               state_d = S_DRAIN;
            end else begin
               rd_en   = 1'b1;
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (abort) begin
               abort_d = 1'b1;
            end
            if (ins_ready) begin
               pc_d     = pc_q + 1'b1;
               remain_d = remain_q - 1'b1;
               cnt_d    = '0;
               // An abort in the accept cycle itself also ends the run
               if ((remain_q == REMAIN_ONE) || abort_q || abort) begin
                  state_d = S_DRAIN;
               end else begin
                  state_d = S_FETCH;
               end
            end
         end
         S_DRAIN: begin
            if (working) begin
               cnt_d = '0;
            end else if (cnt_q == DRAIN_LAST) begin
               cnt_d   = '0;
               done_d  = 1'b1;
               abort_d = 1'b0;
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         pc_q     <= '0;
         remain_q <= '0;
         abort_q  <= 1'b0;
         cnt_q    <= '0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         remain_q <= remain_d;
         abort_q  <= abort_d;
         cnt_q    <= cnt_d;
         done_q   <= done_d;
         err_q    <= err_d;
      end
   end

   assign busy      = (state_q != S_IDLE);
   assign ins_valid = (state_q == S_ISSUE);
   assign done      = done_q;
   assign err       = err_q;

`ifdef INS_FETCH_PERF_EN
   logic [31:0] stall_q;
   logic [31:0] run_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_q <= '0;
         run_q   <= '0;
      end else if ((state_q == S_IDLE) && start) begin
         stall_q <= '0;
         run_q   <= '0;
      end else begin
         if ((state_q == S_ISSUE) && !ins_ready && (stall_q != '1)) begin
            stall_q <= stall_q + 32'd1;
         end
         if (busy && (run_q != '1)) begin
            run_q <= run_q + 32'd1;
         end
      end
   end

   assign stall_cnt = stall_q;
   assign run_cnt   = run_q;
`endif

endmodule

// File: tb/tb_ins_fetch.sv
// Testbench for ins_fetch: directed scenarios plus randomized runs, checked
// against an instruction-memory model and the cycle rules of the fetch
// interface (issue order, bubble after accept, drain-to-done latency).
module tb_ins_fetch;
   import INS_CONST::*;

   localparam int DEPTH     = 1024;
   localparam int DRAIN_CYC = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        wr_en;
   logic [9:0]  wr_addr;
   logic [63:0] wr_data;
   logic        start;
   logic [9:0]  start_addr;
   logic [10:0] start_len;
   logic        abort;
   logic        busy;
   logic        done;
   logic        err;
   logic        ins_valid;
   logic [63:0] ins;
   logic        ins_ready;
   logic        working;
`ifdef INS_FETCH_PERF_EN
   logic [31:0] stall_cnt;
   logic [31:0] run_cnt;
`endif

   int vectors     = 0;
   int miscompares = 0;

   logic [63:0] mem_m [DEPTH];

   always #5 clk = ~clk;

   ins_fetch #(
      .DEPTH     (DEPTH),
      .DRAIN_CYC (DRAIN_CYC)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .start      (start),
      .start_addr (start_addr),
      .start_len  (start_len),
      .abort      (abort),
      .busy       (busy),
      .done       (done),
      .err        (err),
      .ins_valid  (ins_valid),
      .ins        (ins),
      .ins_ready  (ins_ready),
      .working    (working)
`ifdef INS_FETCH_PERF_EN
      ,
      .stall_cnt  (stall_cnt),
      .run_cnt    (run_cnt)
`endif
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic host_write(input int addr, input logic [63:0] data);
      wr_en   = 1'b1;
      wr_addr = 10'(addr);
      wr_data = data;
      step();
      wr_en = 1'b0;
      mem_m[addr % DEPTH] = data;
   endtask

   // One complete run. abort_idx: instruction index during whose ISSUE abort
   // is pulsed (-1 none, needs dly>0). work_hi: cycles working stays high
   // after the final accept. probe: pulse start while busy.
   task automatic run(input int addr, input int len, input int dly,
                      input int abort_idx, input int work_hi, input bit probe);
      int          n_exp;
      logic [63:0] exp_q [$];
      n_exp = (abort_idx >= 0 && abort_idx < len) ? abort_idx + 1 : len;
      for (int i = 0; i < n_exp; i++) exp_q.push_back(mem_m[(addr + i) % DEPTH]);

      start      = 1'b1;
      start_addr = 10'(addr);
      start_len  = 11'(len);
      step();
      start = 1'b0;

      if (len == 0) begin
         chk("zl_done", done, 64'd1);
         chk("zl_busy", busy, 64'd0);
         chk("zl_valid", ins_valid, 64'd0);
         step();
         chk("zl_done_clr", done, 64'd0);
         chk("zl_busy2", busy, 64'd0);
         chk("zl_valid2", ins_valid, 64'd0);
`ifdef INS_FETCH_PERF_EN
         chk("zl_run_cnt", run_cnt, 64'd0);
`endif
         return;
      end

      chk("fetch_busy", busy, 64'd1);
      chk("fetch_valid", ins_valid, 64'd0);

      for (int k = 0; k < n_exp; k++) begin
         step();
         chk("issue_valid", ins_valid, 64'd1);
         chk("issue_ins", ins, exp_q[k]);
         for (int d = 0; d < dly; d++) begin
            if (k == abort_idx && d == 0) abort = 1'b1;
            if (probe && k == 0 && d == 0) start = 1'b1;
            step();
            abort = 1'b0;
            start = 1'b0;
            chk("hold_valid", ins_valid, 64'd1);
            chk("hold_ins", ins, exp_q[k]);
            if (probe && k == 0 && d == 0) chk("err_pulse", err, 64'd1);
            else chk("err_quiet", err, 64'd0);
         end
         ins_ready = 1'b1;
         step();
         ins_ready = 1'b0;
         chk("bubble", ins_valid, 64'd0);
         chk("bubble_busy", busy, 64'd1);
      end

      for (int j = 0; j < work_hi + DRAIN_CYC; j++) begin
         working = (j < work_hi);
         chk("drain_done", done, 64'd0);
         chk("drain_valid", ins_valid, 64'd0);
         chk("drain_busy", busy, 64'd1);
         step();
      end
      working = 1'b0;
      chk("done_pulse", done, 64'd1);
      chk("done_busy", busy, 64'd0);
`ifdef INS_FETCH_PERF_EN
      chk("stall_cnt", stall_cnt, 64'(n_exp * dly));
      chk("run_cnt", run_cnt, 64'(n_exp * (dly + 2) + work_hi + DRAIN_CYC));
`endif
      step();
      chk("done_clr", done, 64'd0);
      chk("idle_valid", ins_valid, 64'd0);
   endtask

   initial begin
      #3000000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int a, n, dl, ab, wh;
      rst       = 1'b1;
      wr_en     = 1'b0;
      wr_addr   = '0;
      wr_data   = '0;
      start     = 1'b0;
      start_addr = '0;
      start_len = '0;
      abort     = 1'b0;
      ins_ready = 1'b0;
      working   = 1'b0;
      step();
      step();
      rst = 1'b0;
      chk("rst_valid", ins_valid, 64'd0);
      chk("rst_ins", ins, 64'd0);
      chk("rst_busy", busy, 64'd0);
      chk("rst_done", done, 64'd0);
      chk("rst_err", err, 64'd0);

      // Three instructions, ready four cycles after each valid
      host_write(5, {OP_CONFIG, 62'($urandom)});
      host_write(6, {OP_LOAD,   62'({$urandom, $urandom})});
      host_write(7, {OP_CALC,   62'({$urandom, $urandom})});
      run(5, 3, 4, -1, 0, 1'b0);

      // Zero-length run
      run(9, 0, 0, -1, 0, 1'b0);

      // Address wrap 1023 -> 0
      host_write(1023, {OP_SAVE, 62'({$urandom, $urandom})});
      host_write(0,    {OP_LOAD, 62'({$urandom, $urandom})});
      run(1023, 2, 1, -1, 0, 1'b0);

      // Long stall in ISSUE
      run(6, 1, 50, -1, 0, 1'b0);

      // Abort during instruction 2 of 5, plus start while busy
      for (int i = 100; i < 105; i++) host_write(i, {$urandom, $urandom});
      run(100, 5, 3, 1, 0, 1'b1);

      // Controller keeps working 20 cycles after the last accept
      run(5, 3, 2, -1, 20, 1'b0);

      // Reset in the middle of ISSUE, program survives
      start      = 1'b1;
      start_addr = 10'd5;
      start_len  = 11'd3;
      step();
      start = 1'b0;
      step();
      chk("pre_rst_valid", ins_valid, 64'd1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("mid_rst_valid", ins_valid, 64'd0);
      chk("mid_rst_busy", busy, 64'd0);
      chk("mid_rst_ins", ins, 64'd0);
      step();
      chk("post_rst_busy", busy, 64'd0);
      run(5, 3, 1, -1, 0, 1'b0);

      // Randomized runs
      for (int r = 0; r < 10; r++) begin
         a  = int'($urandom_range(DEPTH - 1, 0));
         n  = int'($urandom_range(6, 1));
         dl = int'($urandom_range(3, 0));
         ab = (dl > 0 && $urandom_range(1, 0) == 1) ? int'($urandom_range(n - 1, 0)) : -1;
         wh = int'($urandom_range(3, 0));
         for (int i = 0; i < n; i++) host_write((a + i) % DEPTH, {$urandom, $urandom});
         run(a, n, dl, ab, wh, 1'b0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
